spi_register_target: RTL and testbench

- Cycle-accurate SPI responder for the chip register interface: it is the target end of the bit-serial register protocol issued by the FPGA SPI driver.
- Receives write and burst-read frames on `spi_clk`/`serial_in` and drives read bytes on `serial_out` from an internal 8-bit register file.
- Runs on the FPGA system clock and oversamples the SPI lines.
- Used as an on-board chip emulator and as the loopback target in driver bring-up and regression.

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/spi_edge_sync.sv | 34 +++
 rtl/spi_register_target.sv | 157 +++++++++++++++
 tb/tb_spi_register_target.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared FSM states and field widths for the SPI register target
package spi_target_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HEADER     = 3'd1,
    WRITE_DATA = 3'd2,
    READ_COUNT = 3'd3,
    READ_DATA  = 3'd4
  } state_t;
  localparam int HEADER_BITS = 9;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int COUNT_W     = 8;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: synchronizes spi_clk/serial_in into clk and emits registered edge pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_spi_clk,
  input  logic i_serial_in,
  output logic o_rise,
  output logic o_fall,
  output logic o_data
);
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_clk_prev;
  // data gets the same extra register as the edge pulses so sampling stays aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_din_sync <= '0;
      r_clk_prev <= 1'b0;
      o_rise     <= 1'b0;
      o_fall     <= 1'b0;
      o_data     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], i_serial_in};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      o_rise     <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
      o_fall     <= ~r_clk_sync[SYNC_STAGES-1] & r_clk_prev;
      o_data     <= r_din_sync[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/spi_register_target.sv
// spi_register_target: oversampling SPI responder for write and burst-read frames
// against an internal 8-bit register file with a fabric host port.
module spi_register_target
  import spi_target_pkg::*;
#(
  parameter int                 NUM_REGS     = 256,
  parameter int                 SYNC_STAGES  = 2,
  parameter int                 IDLE_TIMEOUT = 1024,
  parameter logic [DATA_W-1:0]  RESET_VALUE  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              serial_in,
  output logic              serial_out,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_byte_done,
  output logic              frame_error,
  output logic              busy
);
  localparam int                AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int                TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [ADDR_W:0]   NR = (ADDR_W + 1)'(NUM_REGS);
  logic [DATA_W-1:0]  r_mem [NUM_REGS];
  state_t             r_state;
  logic [3:0]         r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_shift_out;
  logic [ADDR_W-1:0]  r_addr;
  logic [COUNT_W-1:0] r_count;
  logic               r_last;
  logic [TW-1:0]      r_idle;
  logic               w_rise, w_fall, w_sdata;
  logic [DATA_W-1:0]  w_byte, w_rd_cur, w_rd_next;
  logic [ADDR_W-1:0]  w_next_addr;
  logic               w_cur_map, w_host_map, w_commit, w_timeout;
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_spi_clk  (spi_clk),
    .i_serial_in(serial_in),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_data     (w_sdata)
  );
  assign w_byte      = {r_shift[DATA_W-2:0], w_sdata};
  assign w_next_addr = r_addr + 1'b1;
  assign w_cur_map   = {1'b0, r_addr} < NR;
  assign w_host_map  = {1'b0, host_addr} < NR;
  assign w_rd_cur    = w_cur_map ? r_mem[r_addr[AW-1:0]] : '0;
  assign w_rd_next   = ({1'b0, w_next_addr} < NR) ? r_mem[w_next_addr[AW-1:0]] : '0;
  assign w_commit    = (r_state == WRITE_DATA) && w_rise && (r_bit_cnt == 4'(DATA_W - 1));
  assign w_timeout   = (r_state != IDLE) && !w_rise && !w_fall && (r_idle == TW'(IDLE_TIMEOUT - 1));
  assign busy        = r_state != IDLE;
  // SPI commit is assigned last so it wins a same-address collision with the host
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VALUE;
      host_rdata <= '0;
    end else begin
      if (host_we && w_host_map) r_mem[host_addr[AW-1:0]] <= host_wdata;
      if (w_commit && w_cur_map) r_mem[r_addr[AW-1:0]] <= w_byte;
      host_rdata <= w_host_map ? r_mem[host_addr[AW-1:0]] : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_shift_out  <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_last       <= 1'b0;
      r_idle       <= '0;
      serial_out   <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_byte_done <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      wr_strobe    <= 1'b0;
      rd_byte_done <= 1'b0;
      frame_error  <= 1'b0;
      r_idle       <= (r_state == IDLE || w_rise || w_fall) ? '0 : r_idle + TW'(1);
      if (w_timeout) begin
        r_state     <= IDLE;
        frame_error <= 1'b1;
        serial_out  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_rise && w_sdata) begin
            r_state   <= HEADER;
            r_bit_cnt <= '0;
          end
          HEADER: if (w_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(HEADER_BITS - 1)) begin
              r_addr    <= w_byte;
              r_bit_cnt <= '0;
              r_state   <= r_shift[DATA_W-1] ? WRITE_DATA : READ_COUNT;
            end
          end
          WRITE_DATA: if (w_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(DATA_W - 1)) begin
              wr_strobe <= 1'b1;
              wr_addr   <= r_addr;
              wr_data   <= w_byte;
              r_state   <= IDLE;
            end
          end
          READ_COUNT: if (w_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(DATA_W - 1)) begin
              r_bit_cnt   <= '0;
              r_count     <= w_byte;
              r_shift_out <= w_rd_cur;
              r_last      <= 1'b0;
              r_state     <= (w_byte == '0) ? IDLE : READ_DATA;
            end
          end
          READ_DATA: begin
            // the last bit stays on the line until the driver's sampling rise
            if (w_fall && !r_last) begin
              serial_out  <= r_shift_out[DATA_W-1];
              r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
              r_bit_cnt   <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'(DATA_W - 1)) begin
                rd_byte_done <= 1'b1;
                r_addr       <= w_next_addr;
                r_shift_out  <= w_rd_next;
                r_count      <= r_count - 1'b1;
                r_bit_cnt    <= '0;
                r_last       <= r_count == COUNT_W'(1);
              end
            end else if (w_rise && r_last) begin
              r_state    <= IDLE;
              serial_out <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_register_target.sv
// tb_spi_register_target: drives SPI frames into a 256-register and a 16-register target
// and scoreboards the read-back bytes against a bench-side register model.
module tb_spi_register_target;
  logic clk = 1'b0;
  logic rst, spi_clk, serial_in, host_we;
  logic [7:0] host_addr, host_wdata;
  logic so, wr_strobe, rd_done, ferr, busy;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic so16, wr_strobe16, rd_done16, ferr16, busy16;
  logic [7:0] wr_addr16, wr_data16, host_rdata16;
  int checks = 0, failures = 0;
  int wr_cnt = 0, wr_cnt16 = 0, rd_cnt = 0, fe_cnt = 0, so_cnt = 0;
  logic [7:0] mem [256];
  logic [7:0] mem16 [16];
  logic [7:0] q [$];
  logic [7:0] q16 [$];
  always #5 clk = ~clk;
  spi_register_target u_dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .serial_in(serial_in), .serial_out(so),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .rd_byte_done(rd_done),
    .frame_error(ferr), .busy(busy)
  );
  spi_register_target #(.NUM_REGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .serial_in(serial_in), .serial_out(so16),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata16),
    .wr_strobe(wr_strobe16), .wr_addr(wr_addr16), .wr_data(wr_data16), .rd_byte_done(rd_done16),
    .frame_error(ferr16), .busy(busy16)
  );
  always @(posedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (wr_strobe16) wr_cnt16++;
    if (rd_done) rd_cnt++;
    if (ferr) fe_cnt++;
    if (so) so_cnt++;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic b, input logic col, output logic o, output logic o16);
    @(negedge clk) serial_in = b;
    repeat (8) @(negedge clk);
    o = so;
    o16 = so16;
    spi_clk = 1'b1;
    if (col) begin
      repeat (3) @(negedge clk);
      host_we = 1'b1; host_addr = 8'h12; host_wdata = 8'h00;
      @(negedge clk) host_we = 1'b0;
      repeat (4) @(negedge clk);
    end else repeat (8) @(negedge clk);
    spi_clk = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v, input logic col_last);
    logic o, o16;
    for (int i = 7; i >= 0; i--) xfer(v[i], col_last && i == 0, o, o16);
  endtask
  task automatic spi_write(input logic [7:0] a, input logic [7:0] d, input logic col);
    logic o, o16;
    xfer(1'b1, 1'b0, o, o16);
    xfer(1'b1, 1'b0, o, o16);
    send_byte(a, 1'b0);
    send_byte(d, col);
    mem[a] = d;
    if (a < 8'd16) mem16[a[3:0]] = d;
    repeat (10) @(negedge clk);
  endtask
  task automatic spi_read(input logic [7:0] a, input logic [7:0] n);
    logic o, o16;
    logic [7:0] b, b16, aa;
    for (int k = 0; k < int'(n); k++) begin
      aa = a + 8'(k);
      q.push_back(mem[aa]);
      q16.push_back(aa < 8'd16 ? mem16[aa[3:0]] : 8'h00);
    end
    xfer(1'b1, 1'b0, o, o16);
    xfer(1'b0, 1'b0, o, o16);
    send_byte(a, 1'b0);
    send_byte(n, 1'b0);
    for (int k = 0; k < int'(n); k++) begin
      for (int i = 7; i >= 0; i--) begin
        xfer(1'b0, 1'b0, o, o16);
        b[i] = o;
        b16[i] = o16;
      end
      check("rd_byte", b, q.pop_front());
      check("rd_byte16", b16, q16.pop_front());
    end
    repeat (20) @(negedge clk);
  endtask
  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk) begin host_we = 1'b1; host_addr = a; host_wdata = d; end
    @(negedge clk) host_we = 1'b0;
    mem[a] = d;
    if (a < 8'd16) mem16[a[3:0]] = d;
  endtask
  task automatic host_read(input logic [7:0] a, output logic [7:0] r, output logic [7:0] r16);
    @(negedge clk) host_addr = a;
    @(negedge clk);
    r = host_rdata;
    r16 = host_rdata16;
  endtask
  initial begin
    logic [7:0] r, r16;
    logic o, o16;
    int w0, r0, s0, f0, el;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem16[i] = 8'h00;
    rst = 1'b1; spi_clk = 1'b0; serial_in = 1'b0;
    host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_serial_out", so, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    // plain write
    w0 = wr_cnt;
    spi_write(8'h12, 8'hA5, 1'b0);
    check("wr_strobe_cnt", wr_cnt - w0, 1);
    check("wr_addr", wr_addr, 8'h12);
    check("wr_data", wr_data, 8'hA5);
    host_read(8'h12, r, r16);
    check("host_rd_12", r, 8'hA5);
    check("host16_rd_12_unmapped", r16, 8'h00);
    // burst read wrapping past 0xFF
    host_write(8'hFE, 8'h11);
    host_write(8'hFF, 8'h22);
    host_write(8'h00, 8'h33);
    r0 = rd_cnt;
    spi_read(8'hFE, 8'd3);
    check("burst_rd_done_cnt", rd_cnt - r0, 3);
    check("burst_so_after", so, 0);
    check("burst_busy_after", busy, 0);
    // zero-count read
    r0 = rd_cnt;
    s0 = so_cnt;
    spi_read(8'h05, 8'd0);
    check("zero_busy", busy, 0);
    check("zero_so_cycles", so_cnt - s0, 0);
    check("zero_rd_done", rd_cnt - r0, 0);
    // timeout after 4 header bits
    xfer(1'b1, 1'b0, o, o16);
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, o, o16);
    check("to_busy_mid", busy, 1);
    f0 = fe_cnt;
    el = 0;
    for (int i = 0; i < 1200 && fe_cnt == f0; i++) begin
      @(negedge clk);
      el++;
    end
    check("to_latency_window", (el >= 1020 && el <= 1040), 1);
    repeat (10) @(negedge clk);
    check("to_frame_error_cnt", fe_cnt - f0, 1);
    check("to_busy_after", busy, 0);
    host_read(8'h12, r, r16);
    check("to_regs_intact", r, 8'hA5);
    spi_write(8'h30, 8'h5A, 1'b0);
    check("to_next_wr_data", wr_data, 8'h5A);
    host_read(8'h30, r, r16);
    check("to_next_host_rd", r, 8'h5A);
    // unmapped address on the 16-register target
    w0 = wr_cnt16;
    spi_write(8'h20, 8'h77, 1'b0);
    check("um_wr_strobe_cnt", wr_cnt16 - w0, 1);
    check("um_wr_addr", wr_addr16, 8'h20);
    check("um_wr_data", wr_data16, 8'h77);
    host_read(8'h00, r, r16);
    check("um_no_alias", r16, 8'h33);
    host_read(8'h20, r, r16);
    check("um_host_rd", r16, 8'h00);
    check("mapped_host_rd_20", r, 8'h77);
    spi_read(8'h20, 8'd1);
    // host write colliding with SPI commit
    host_write(8'h12, 8'h3C);
    spi_write(8'h12, 8'hA5, 1'b1);
    host_read(8'h12, r, r16);
    check("collision_spi_wins", r, 8'hA5);
    // reset in the middle of READ_DATA
    xfer(1'b1, 1'b0, o, o16);
    xfer(1'b0, 1'b0, o, o16);
    send_byte(8'h12, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (8) @(negedge clk);
    check("pre_rst_so_msb", so, 1);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_so_immediate", so, 0);
    check("rst_busy_immediate", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem16[i] = 8'h00;
    host_read(8'h12, r, r16);
    check("rst_reg_12", r, 8'h00);
    host_read(8'hFE, r, r16);
    check("rst_reg_fe", r, 8'h00);
    spi_read(8'h12, 8'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
